// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and the fetched-instruction record for the fetch unit.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 2;
  localparam logic [31:0] PC_INCR            = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Shift-style buffer of fetched instructions; entry 0 is always the head.
module fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  entries_q [DEPTH];
  fetch_entry_t  entries_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] wr_idx;

  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    // On a simultaneous pop the shift frees the slot below the current tail.
    wr_idx    = pop ? count_q - 1'b1 : count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
          entries_d[i] = entries_q[i+1];
        end
      end
      if (push) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr_idx) entries_d[i] = push_data;
        end
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
    entries_q <= entries_d;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? entries_q[0] : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetcher: PC/in-flight tracking with a small decode buffer.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          pop, push, issue;
  fetch_entry_t  head, push_data;

  assign if_valid  = (count != '0);
  assign if_pc     = head.pc;
  assign if_instr  = head.instr;
  assign imem_addr = pc_q;

  // Counting the outstanding fetch guarantees its response always has a slot.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight_q);
  assign pop       = if_valid & id_ready & ~redirect_valid;
  assign issue     = ~redirect_valid & ((occupancy < (CW+1)'(FIFO_DEPTH)) | pop);
  assign push      = inflight_q & ~redirect_valid;
  assign push_data = '{pc: inflight_pc_q, instr: imem_rdata};

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'h3;
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + PC_INCR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_data),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle vector table plus scoreboarded stream sequences.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  logic sb_en = 1'b0;
  fetch_entry_t exp_q[$];

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous instruction memory: data for the address presented this cycle arrives next cycle.
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_expect(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: start + 32'(4 * i), instr: mem_word(start + 32'(4 * i))});
    end
  endtask

  task automatic drain(input int budget);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      step();
      cyc++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    redirect_valid = 1'b0;
    id_ready = rdy;
    repeat (2) step();
    exp_q.delete();
    reset = 1'b0;
  endtask

  // Scoreboard: every entry decode accepts must be the next expected {pc, instr}.
  always @(negedge clk) begin
    if (sb_en && if_valid && id_ready && !redirect_valid && !reset) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h expected no entry", if_pc);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        check("sb_pc", if_pc, e.pc);
        check("sb_instr", if_instr, e.instr);
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        rdr;
    logic [31:0] rdr_pc;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
  } vec_t;

  localparam int NV = 22;
  localparam logic [31:0] W0 = 32'h1000_0000;
  vec_t vecs [NV];

  initial begin
    // Outputs expected just after each edge, given the inputs held during the preceding cycle.
    vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,       32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,       32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,       32'h4};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   W0 + 32'd0,  32'h8};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   W0 + 32'd1,  32'hC};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   W0 + 32'd2,  32'h10};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   W0 + 32'd2,  32'h10};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   W0 + 32'd2,  32'h10};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   W0 + 32'd2,  32'h10};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   W0 + 32'd2,  32'h10};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   W0 + 32'd2,  32'h10};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   W0 + 32'd3,  32'h14};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  W0 + 32'd4,  32'h18};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h14,  W0 + 32'd5,  32'h1C};
    vecs[14] = '{1'b0, 1'b1, 32'h43,  1'b1, 1'b0, 32'h0,   32'h0,       32'h40};
    vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,       32'h44};
    vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h40,  W0 + 32'h10, 32'h48};
    vecs[17] = '{1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0,   32'h0,       32'h100};
    vecs[18] = '{1'b0, 1'b1, 32'h206, 1'b1, 1'b0, 32'h0,   32'h0,       32'h204};
    vecs[19] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,       32'h208};
    vecs[20] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, W0 + 32'h81, 32'h20C};
    vecs[21] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h208, W0 + 32'h82, 32'h210};

    for (int i = 0; i < NV; i++) begin
      reset          = vecs[i].rst;
      redirect_valid = vecs[i].rdr;
      redirect_pc    = vecs[i].rdr_pc;
      id_ready       = vecs[i].rdy;
      step();
      check($sformatf("v%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_pc", i), if_pc, vecs[i].exp_pc);
      check($sformatf("v%0d_instr", i), if_instr, vecs[i].exp_instr);
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
    end

    // Redirect to an unaligned target while the buffer is full.
    reset = 1'b1;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    sb_en = 1'b1;
    do_reset(1'b0);
    repeat (4) step();
    check("a_full_head_pc", if_pc, 32'h0);
    check("a_held_addr", imem_addr, 32'h8);
    sb_expect(32'h40, 6);
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    id_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("a_r1_valid", 32'(if_valid), 32'd0);
    step();
    check("a_r2_valid", 32'(if_valid), 32'd0);
    step();
    check("a_r3_valid", 32'(if_valid), 32'd1);
    check("a_r3_pc", if_pc, 32'h40);
    drain(30);
    id_ready = 1'b0;

    // Redirect coinciding with a pop and an arriving response.
    do_reset(1'b1);
    sb_expect(32'h0, 3);
    drain(20);
    check("b_head_valid", 32'(if_valid), 32'd1);
    check("b_head_pc", if_pc, 32'hC);
    sb_expect(32'h200, 4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    check("b_flushed", 32'(if_valid), 32'd0);
    drain(20);

    // One-cycle reset pulse mid-stream.
    exp_q.delete();
    sb_expect(32'h0, 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("c_valid", 32'(if_valid), 32'd0);
    check("c_pc", if_pc, 32'h0);
    check("c_addr", imem_addr, 32'h0);
    drain(20);
    id_ready = 1'b0;

    // PC wrap at the top of the address space.
    sb_expect(32'hFFFF_FFFC, 3);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    id_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("d_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    check("d_addr_wrap", imem_addr, 32'h0);
    drain(20);
    id_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
